// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle digit-serial add/subtract unit.
//
// Works through the operands CHUNK bits per clock, least-significant chunk first.
// It uses a start/busy/done handshake and produces ALU-style status flags.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits processed per cycle; must divide WIDTH
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      request; accepted only in idle or done state
//   op         00 add, 01 sub, 10 inc (a+1), 11 dec (a-1)
//   a, b       operands, latched on accept (b ignored for inc/dec)
//   busy       operation in progress
//   done       one-cycle pulse, result valid
//   sum        result, held until the next accepted start
//   carry_out  carry out of the MSB (sub/dec: 1 = no borrow)
//   overflow   signed two's-complement overflow
//   zero       sum == 0
//   neg        sum[WIDTH-1]
//
// Optional build macro
//   ADDSUB_SATURATE_EN  saturate sum to the signed limit on overflow

module addsub_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned NChunk = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;      // effective B operand
  logic               carry_q, carry_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]   res_q, res_d;  // working result, separate from the held output
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;

  logic [31:0]        base;
  logic [CHUNK-1:0]   a_sl, b_sl;
  logic [CHUNK:0]     sl_sum;
  logic               ovf_w;
  logic [WIDTH-1:0]   fin_sum;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    base    = 32'(idx_q) * CHUNK;
    a_sl    = a_q[base +: CHUNK];
    b_sl    = b_q[base +: CHUNK];
    sl_sum  = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK + 1)'(carry_q);
    res_d[base +: CHUNK] = sl_sum[CHUNK-1:0];

    // Same-signed operands giving a differently-signed result is equivalent
    // to carry-into-MSB xor carry-out-of-MSB.
    ovf_w   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
    // Overflow direction follows the common operand sign.
    fin_sum = ovf_w ? {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}} : res_d;
`else
    fin_sum = res_d;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          idx_d   = '0;
          carry_d = (op == 2'b01) || (op == 2'b10);
          unique case (op)
            2'b00:   b_d = b;
            2'b01:   b_d = ~b;
            2'b10:   b_d = '0;
            default: b_d = '1;
          endcase
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        carry_d = sl_sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
          sum_d   = fin_sum;
          cout_d  = sl_sum[CHUNK];
          ovf_d   = ovf_w;
          zero_d  = (fin_sum == '0);
          neg_d   = fin_sum[WIDTH-1];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, multi-cycle, digit-serial add/subtract unit. Successor to the combinational 16-bit adder and incrementer.
- Processes CHUNK bits per clock, least-significant chunk first, so area can be traded against latency.
- Uses a start/busy/done handshake and produces ALU-style status flags.
- Sits beside the ALU and serves wide or area-constrained arithmetic in the CPU datapath.

Parameters:
- WIDTH, 16, operand and result width in bits; must be at least 2.
- CHUNK, 4, bits processed per cycle. Must divide WIDTH exactly. Elaboration fails otherwise.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE state
- op  in  2  00 add (a+b), 01 sub (a-b), 10 inc (a+1), 11 dec (a-1)
- a  in  WIDTH  operand A; latched when start is accepted
- b  in  WIDTH  operand B; latched when start is accepted; ignored for inc/dec
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; result valid
- sum  out  WIDTH  result; held until the next accepted start
- carry_out  out  1  carry out of the MSB (for sub/dec: 1 = no borrow)
- overflow  out  1  signed two's-complement overflow
- zero  out  1  sum == 0
- neg  out  1  sum[WIDTH-1]

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - On reset: state=IDLE; busy, done, sum, carry_out, overflow, zero and neg all = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, op, and an effective B operand: b for add; ~b for sub; 0 for inc; all-ones for dec.
  - Carry-in: 1 for sub and inc; 0 for add and dec.
  - Chunk counter cleared. Next state = RUN. busy=1 from the next cycle.
- RUN:
  - Each cycle adds the current CHUNK slice of A and effective B plus the running carry.
  - Writes that slice of the sum register and keeps the carry for the next slice.
  - After the slice at index WIDTH/CHUNK-1: next state = DONE.
  - carry_out = final carry.
  - overflow = carry into MSB XOR carry out of MSB.
- DONE (exactly one cycle):
  - done=1, busy=0. sum and flags are valid and stay stable until the next accepted start.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation). Otherwise next state = IDLE.
- Latency: start accepted at edge N; done=1 in the cycle after edge N+WIDTH/CHUNK.
  - WIDTH=16, CHUNK=4: done is seen 4 cycles after the start edge. Throughput is one result per WIDTH/CHUNK+1 cycles.
- start while in RUN: ignored. No queueing and no error flag.
- Changes to a, b or op after acceptance have no effect on the operation in flight.
- Flag timing:
  - zero and neg are derived from the registered sum.
  - sum and all flags update only at the transition into DONE.
  - While RUN is in progress, the previous result remains on the outputs.
- Wrap-around: results are modulo 2^WIDTH. For example, MAX+1 = MIN and MIN-1 = MAX, each with overflow=1.
- CHUNK=WIDTH is legal: RUN lasts one cycle.
- reset during RUN or DONE: abort and go to IDLE. All outputs clear on the next edge, and there is no done pulse.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: when overflow=1, sum saturates to the signed limit.
  - Positive overflow gives 0111…1.
  - Negative overflow gives 1000…0.
  - overflow still reads 1. carry_out, zero and neg reflect the saturated sum (carry_out unchanged).
- Undefined: sum wraps modulo 2^WIDTH. There is no saturation logic.

Test Plan:
- Latency and overflow (WIDTH=16, CHUNK=4): add 0x7FFF+0x0001 → done exactly 4 cycles after the start edge. sum=0x8000, overflow=1, neg=1, carry_out=0, zero=0.
- Subtract with borrow: sub 0x0000-0x0001 → sum=0xFFFF, carry_out=0, neg=1, overflow=0. Then sub 0x0005-0x0003 → sum=0x0002, carry_out=1.
- Inc/dec wrap: inc 0xFFFF → sum=0x0000, zero=1, carry_out=1. dec 0x8000 → sum=0x7FFF, overflow=1.
- Handshake:
  - start pulsed again mid-RUN with different operands → ignored; the first result is returned.
  - start held high through DONE → second operation accepted with no idle cycle; two done pulses exactly 5 cycles apart.
- Abort: reset asserted in the 2nd RUN cycle of 0x1234+0x1111 → next cycle: IDLE, all outputs 0, no done pulse. A following add of 0x0002+0x0002 gives sum=0x0004.
- Parameter sweep and saturation:
  - For CHUNK ∈ {1,4,16}: 1000 random a/b/op triples match $signed reference arithmetic, with latency WIDTH/CHUNK.
  - With ADDSUB_SATURATE_EN defined: 0x7FFF+0x7FFF → 0x7FFF, and 0x8000+0xFFFF → 0x8000, both with overflow=1.
